// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receiver for 16x-oversampled UART frames (8N1 by default) with a small
//   first-word-fall-through output FIFO. The serial line is synchronised with
//   two flops. Each bit is sampled at its midpoint: the start bit after 8
//   ticks, then every 16 ticks after that. Good bytes are pushed into the
//   FIFO. Framing errors, FIFO overflows and (optionally) parity errors are
//   each reported as a 1-cycle pulse.
//
//   Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
//   between the data bits and the stop bit (8E1 framing). Without it,
//   parity_err is tied to 0.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   rx          serial line, idle high, asynchronous to clk
//   baud_tick   1-cycle strobe at 16x the baud rate
//   rd_en       pop the head of the FIFO (ignored when empty)
//   rd_data     head of the FIFO, valid while empty==0 (0 while empty)
//   empty       FIFO holds no bytes
//   full        FIFO holds 2**FIFO_AW bytes
//   frame_err   1-cycle pulse: stop bit sampled low
//   overflow    1-cycle pulse: good byte arrived while full and not popped
//   parity_err  1-cycle pulse: parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int FIFO_AW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            baud_tick,
   input  logic            rd_en,
   output logic [DBIT-1:0] rd_data,
   output logic            empty,
   output logic            full,
   output logic            frame_err,
   output logic            overflow,
   output logic            parity_err
);

   localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int DEPTH = 2 ** FIFO_AW;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state_reg, state_next;
   logic [3:0]      s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            rx_meta_reg, rx_sync_reg;
   logic            push, ferr_next;
   logic            frame_err_reg, overflow_reg;
`ifdef UART_RX_PARITY_EN
   logic            par_bad_reg, par_bad_next, perr_next, parity_err_reg;
`endif

   // FIFO state
   logic [DBIT-1:0]    mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic               pop, wr;

   // ---------------- receiver: state registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         s_reg       <= '0;
         n_reg       <= '0;
         b_reg       <= '0;
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
         par_bad_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         s_reg       <= s_next;
         n_reg       <= n_next;
         b_reg       <= b_next;
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
`ifdef UART_RX_PARITY_EN
         par_bad_reg <= par_bad_next;
`endif
      end
   end

   // ---------------- receiver: next state ----------------
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      push       = 1'b0;
      ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_next = par_bad_reg;
      perr_next    = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (!rx_sync_reg) begin
               state_next = START;
               s_next     = '0;
`ifdef UART_RX_PARITY_EN
               par_bad_next = 1'b0;
`endif
            end
         end
         START: begin
            if (baud_tick) begin
               if (s_reg == 4'd7) begin
                  // Mid start bit: still low means a real frame.
                  // High means it was only a glitch.
                  if (!rx_sync_reg) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (s_reg == 4'd15) begin
                  // LSB arrives first, so shift each new bit in at the MSB end.
                  b_next = {rx_sync_reg, b_reg[DBIT-1:1]};
                  s_next = '0;
                  if (n_reg == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end else begin
                     n_next = n_reg + NW'(1);
                  end
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               if (s_reg == 4'd15) begin
                  // Even parity: the data bits plus the parity bit must hold
                  // an even number of ones.
                  par_bad_next = ^{rx_sync_reg, b_reg};
                  perr_next    = par_bad_next;
                  s_next       = '0;
                  state_next   = STOP;
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
`endif
         STOP: begin
            if (baud_tick) begin
               if (s_reg == 4'(SB_TICK - 1)) begin
                  state_next = IDLE;
                  s_next     = '0;
`ifdef UART_RX_PARITY_EN
                  // A parity failure has already been reported for this frame,
                  // so drop the byte quietly whatever the stop bit holds.
                  push      =  rx_sync_reg & ~par_bad_reg;
                  ferr_next = ~rx_sync_reg & ~par_bad_reg;
`else
                  push      =  rx_sync_reg;
                  ferr_next = ~rx_sync_reg;
`endif
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FIFO ----------------
   assign empty = (count_reg == '0);
   assign full  = (count_reg == (FIFO_AW + 1)'(DEPTH));
   assign pop   = rd_en & ~empty;
   // When the FIFO is full, a pop in the same cycle frees the slot being written.
   assign wr    = push & (~full | pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         frame_err_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         if (wr)
            wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
         count_reg     <= count_reg + (FIFO_AW + 1)'(wr) - (FIFO_AW + 1)'(pop);
         frame_err_reg <= ferr_next;
         overflow_reg  <= push & ~wr;
      end
   end

   // The storage has no reset. The output is forced to 0 while empty, so stale
   // contents never appear on rd_data.
   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr_reg] <= b_reg;
   end

   assign rd_data   = empty ? '0 : mem[rd_ptr_reg];
   assign frame_err = frame_err_reg;
   assign overflow  = overflow_reg;

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         parity_err_reg <= 1'b0;
      else
         parity_err_reg <= perr_next;
   end
   assign parity_err = parity_err_reg;
`else
   assign parity_err = 1'b0;
`endif

endmodule
